multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle variant of the MIPS datapath. Replaces the single-cycle combinational control.
- Sequences each instruction over 3-5 states: fetch, decode, execute, memory and write-back. Drives the PC, IR, register-file, ALU-mux and memory enables from the IR opcode.
- Stretches memory states with a ready handshake, so one shared instruction/data memory can have variable latency.

Parameters:
OP_R, 6'h00, R-type opcode
OP_LW, 6'h23, load word opcode
OP_SW, 6'h2B, store word opcode
OP_BEQ, 6'h04, branch-equal opcode
OP_J, 6'h02, jump opcode
OP_ADDI, 6'h08, add-immediate opcode

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
opcode  in  6  IR[31:26], valid from DECODE onward
mem_ready  in  1  memory completes the current access this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load when ALU zero=1
IorD  out  1  memory address select: 0=PC, 1=ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  IR load
MemtoReg  out  1  write-back source: 1=MDR, 0=ALUOut
PCSource  out  2  PC mux select: 00=ALU, 01=ALUOut, 10=jump target
ALUOp  out  2  00=add, 01=sub, 10=funct decode
ALUSrcA  out  1  ALU A select: 0=PC, 1=reg A
ALUSrcB  out  2  ALU B select: 00=reg B, 01=4, 10=sign-extended imm, 11=sign-extended imm<<2
RegWrite  out  1  register-file write enable
RegDst  out  1  destination register: 1=rd, 0=rt
instr_done  out  1  one-cycle pulse in the last state of each instruction
state  out  4  current state, for debug
illegal_op  out  1  trap flag (see Optional Feature)

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXECUTE=7, R_WB=8, BRANCH=9, JUMP=10, ADDI_EX=11, ADDI_WB=12, TRAP=13.
- Reset: state=IDLE. All outputs are 0 while reset is high and while in IDLE. IDLE always goes to FETCH on the next clock.
- Outputs are Moore-decoded from state. Any output not listed for a state is 0.
- FETCH: MemRead=1, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite assert only in a cycle with mem_ready=1. They are gated combinationally, so the IR and PC update exactly once per fetch.
  - mem_ready=0: stay in FETCH. mem_ready=1: go to DECODE.
- DECODE: ALUSrcB=11, ALUOp=00.
  - lw or sw: go to MEM_ADDR.
  - R-type: go to EXECUTE.
  - beq: go to BRANCH.
  - j: go to JUMP.
  - addi: go to ADDI_EX.
  - Any other opcode: see Optional Feature.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw goes to MEM_READ; sw goes to MEM_WRITE.
- MEM_READ: MemRead=1, IorD=1. Hold while mem_ready=0; go to MEM_WB on mem_ready=1.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1. Go to FETCH.
- MEM_WRITE: MemWrite=1, IorD=1.
  - MemWrite stays high across wait cycles; the memory samples it on the mem_ready cycle.
  - On mem_ready=1: instr_done=1, go to FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1. Go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1. Go to FETCH.
- JUMP: PCWrite=1, PCSource=10, instr_done=1. Go to FETCH.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1. Go to FETCH.
- Zero-wait latency in cycles: beq=3, j=3, R-type=4, sw=4, addi=4, lw=5. Each wait cycle adds exactly 1.
- mem_ready is ignored in every state except FETCH, MEM_READ and MEM_WRITE.
- Reset asserted mid-instruction: immediate return to IDLE. All enables drop in the same cycle, with no partial RegWrite or MemWrite.
- The opcode input is sampled only in DECODE and MEM_ADDR.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined: an unknown opcode in DECODE goes to TRAP. In TRAP all enables are 0, illegal_op=1, and the FSM stays there until reset.
- Undefined: an unknown opcode in DECODE goes to FETCH with instr_done=1 (executes as a NOP). illegal_op is tied to 0 and TRAP is unreachable.

Test Plan:
- Reset/startup: assert reset for 3 cycles, then release with mem_ready=1 -> all outputs 0 during reset and IDLE. FETCH on the 2nd edge after release, with MemRead=1, IRWrite=1, PCWrite=1.
- lw 0x8C080004 with mem_ready=1 -> states 1,2,3,4,5, then back to 1. RegWrite=1 and MemtoReg=1 only in MEM_WB. instr_done pulses once.
- R-type add 0x01095020, then addi 0x2008000A -> 4 states each. R_WB has RegDst=1; ADDI_WB has RegDst=0. ALUOp=10 only in EXECUTE.
- beq 0x11090002, then j 0x08000010 -> 3 cycles each. BRANCH shows PCWriteCond=1, ALUOp=01, PCSource=01. JUMP shows PCWrite=1, PCSource=10.
- Wait states: sw 0xAC0A0008 with mem_ready low for 2 cycles in FETCH and 3 cycles in MEM_WRITE -> 9 total cycles. IRWrite and PCWrite high for exactly 1 cycle. MemWrite high for 4 cycles.
- Illegal opcode 0xFC000000 -> with ILLEGAL_OP_TRAP_EN: state=13, illegal_op=1, held for 10+ cycles until reset. Without it: FETCH after DECODE with instr_done=1. Also assert reset during MEM_READ -> all enables 0 in the same cycle.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// with a mem_ready stretch on memory states. `ILLEGAL_OP_TRAP_EN` traps unknown opcodes.
//
// state     | meaning
// ----------+--------------------------------------------------
// IDLE      | after reset, all enables low
// FETCH     | read instruction at PC, PC+4 (waits on mem_ready)
// DECODE    | register read, branch target into ALUOut
// MEM_ADDR  | effective address for lw/sw
// MEM_READ  | data read (waits on mem_ready)
// MEM_WB    | MDR to rt
// MEM_WRITE | data write (waits on mem_ready)
// EXECUTE   | R-type ALU operation
// R_WB      | ALUOut to rd
// BRANCH    | beq compare and conditional PC load
// JUMP      | PC load from jump target
// ADDI_EX   | reg A + sign-extended immediate
// ADDI_WB   | ALUOut to rt
// TRAP      | unknown opcode, held until reset
module multicycle_ctrl #(
  parameter logic [5:0] OP_R    = 6'h00,
  parameter logic [5:0] OP_LW   = 6'h23,
  parameter logic [5:0] OP_SW   = 6'h2B,
  parameter logic [5:0] OP_BEQ  = 6'h04,
  parameter logic [5:0] OP_J    = 6'h02,
  parameter logic [5:0] OP_ADDI = 6'h08
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       instr_done,
  output logic [3:0] state,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    EXECUTE   = 4'd7,
    R_WB      = 4'd8,
    BRANCH    = 4'd9,
    JUMP      = 4'd10,
    ADDI_EX   = 4'd11,
    ADDI_WB   = 4'd12,
    TRAP      = 4'd13
  } state_t;

  state_t cur_state, nxt_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur_state <= IDLE;
    else       cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = IDLE;
    case (cur_state)
      IDLE:      nxt_state = FETCH;
      FETCH:     nxt_state = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: nxt_state = MEM_ADDR;
          OP_R:         nxt_state = EXECUTE;
          OP_BEQ:       nxt_state = BRANCH;
          OP_J:         nxt_state = JUMP;
          OP_ADDI:      nxt_state = ADDI_EX;
`ifdef ILLEGAL_OP_TRAP_EN
          default:      nxt_state = TRAP;
`else
          default:      nxt_state = FETCH;
`endif
        endcase
      end
      MEM_ADDR:  nxt_state = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      MEM_READ:  nxt_state = mem_ready ? MEM_WB : MEM_READ;
      MEM_WB:    nxt_state = FETCH;
      MEM_WRITE: nxt_state = mem_ready ? FETCH : MEM_WRITE;
      EXECUTE:   nxt_state = R_WB;
      R_WB:      nxt_state = FETCH;
      BRANCH:    nxt_state = FETCH;
      JUMP:      nxt_state = FETCH;
      ADDI_EX:   nxt_state = ADDI_WB;
      ADDI_WB:   nxt_state = FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
      TRAP:      nxt_state = TRAP;
`endif
      default:   nxt_state = IDLE;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    case (cur_state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // IR and PC load only on the completing cycle so a stretched fetch updates once
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
`ifndef ILLEGAL_OP_TRAP_EN
        case (opcode)
          OP_LW, OP_SW, OP_R, OP_BEQ, OP_J, OP_ADDI: instr_done = 1'b0;
          default:                                   instr_done = 1'b1;
        endcase
`endif
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEM_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      MEM_WRITE: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      R_WB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
      end
      JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ADDI_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
`ifdef ILLEGAL_OP_TRAP_EN
      TRAP: illegal_op = 1'b1;
`endif
      default: ;
    endcase
  end

  assign state = cur_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed instructions, wait-state and reset cases,
// then random instruction streams checked against a per-instruction path model.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic       ALUSrcA, RegWrite, RegDst, instr_done, illegal_op;
  logic [3:0] state;

  int checks = 0;
  int passed = 0;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .PCSource(PCSource),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
    .RegDst(RegDst), .instr_done(instr_done), .state(state), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  wire [16:0] enables = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                         PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, instr_done};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reset held from now for n cycles, then released; ends in the IDLE cycle.
  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) begin
      @(negedge clk);
      chk("rst_state", state, 0);
      chk("rst_enables", {illegal_op, enables}, 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_state", state, 0);
    chk("idle_enables", {illegal_op, enables}, 0);
  endtask

  // Expected path: fetch stretched by fw, memory stretched by mw; other cycles
  // get a random mem_ready since it must be ignored there.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    int exp_st[$];
    bit rdy[$];
    int n_done, done_at, n_ir, n_pc, n_rw, n_mwr, n_mrd, n_pcc;
    bit is_lw, is_sw, is_r, is_addi, is_beq, is_j;
    is_lw = (op == 6'h23); is_sw = (op == 6'h2B); is_r = (op == 6'h00);
    is_addi = (op == 6'h08); is_beq = (op == 6'h04); is_j = (op == 6'h02);
    n_done = 0; done_at = -1; n_ir = 0; n_pc = 0; n_rw = 0; n_mwr = 0; n_mrd = 0; n_pcc = 0;
    repeat (fw) begin exp_st.push_back(1); rdy.push_back(1'b0); end
    exp_st.push_back(1); rdy.push_back(1'b1);
    exp_st.push_back(2); rdy.push_back(1'($urandom_range(0, 1)));
    if (is_lw) begin
      exp_st.push_back(3); rdy.push_back(1'($urandom_range(0, 1)));
      repeat (mw) begin exp_st.push_back(4); rdy.push_back(1'b0); end
      exp_st.push_back(4); rdy.push_back(1'b1);
      exp_st.push_back(5); rdy.push_back(1'($urandom_range(0, 1)));
    end else if (is_sw) begin
      exp_st.push_back(3); rdy.push_back(1'($urandom_range(0, 1)));
      repeat (mw) begin exp_st.push_back(6); rdy.push_back(1'b0); end
      exp_st.push_back(6); rdy.push_back(1'b1);
    end else if (is_r) begin
      exp_st.push_back(7); rdy.push_back(1'($urandom_range(0, 1)));
      exp_st.push_back(8); rdy.push_back(1'($urandom_range(0, 1)));
    end else if (is_addi) begin
      exp_st.push_back(11); rdy.push_back(1'($urandom_range(0, 1)));
      exp_st.push_back(12); rdy.push_back(1'($urandom_range(0, 1)));
    end else if (is_beq) begin
      exp_st.push_back(9); rdy.push_back(1'($urandom_range(0, 1)));
    end else if (is_j) begin
      exp_st.push_back(10); rdy.push_back(1'($urandom_range(0, 1)));
    end
    for (int k = 0; k < exp_st.size(); k++) begin
      @(posedge clk); #1;
      opcode = op;
      mem_ready = rdy[k];
      @(negedge clk);
      chk($sformatf("state op=%0h cyc=%0d", op, k), state, exp_st[k]);
      chk("illegal_op_low", illegal_op, 0);
      chk("aluop_funct_only_in_execute", (ALUOp == 2'b10), (exp_st[k] == 7));
      if (exp_st[k] == 5) chk("mem_wb_ctrl", {RegWrite, MemtoReg, RegDst}, 3'b110);
      if (exp_st[k] == 8) chk("r_wb_ctrl", {RegWrite, MemtoReg, RegDst}, 3'b101);
      if (exp_st[k] == 12) chk("addi_wb_ctrl", {RegWrite, MemtoReg, RegDst}, 3'b100);
      if (exp_st[k] == 9) chk("branch_ctrl", {PCWriteCond, ALUOp, PCSource}, 5'b1_01_01);
      if (exp_st[k] == 10) chk("jump_ctrl", {PCWrite, PCSource}, 3'b1_10);
      if (instr_done) begin n_done++; done_at = k; end
      n_ir += int'(IRWrite);
      n_pc += int'(PCWrite);
      n_rw += int'(RegWrite);
      n_mwr += int'(MemWrite);
      n_mrd += int'(MemRead);
      n_pcc += int'(PCWriteCond);
    end
    chk("instr_done_count", n_done, 1);
    chk("instr_done_last_cycle", done_at, exp_st.size() - 1);
    chk("irwrite_count", n_ir, 1);
    chk("pcwrite_count", n_pc, is_j ? 2 : 1);
    chk("regwrite_count", n_rw, (is_lw || is_r || is_addi) ? 1 : 0);
    chk("memwrite_cycles", n_mwr, is_sw ? mw + 1 : 0);
    chk("memread_cycles", n_mrd, fw + 1 + (is_lw ? mw + 1 : 0));
    chk("pcwritecond_count", n_pcc, is_beq ? 1 : 0);
  endtask

  initial begin
    logic [5:0] ops [7];
    int n_ops;
    ops[0] = 6'h23; ops[1] = 6'h2B; ops[2] = 6'h00; ops[3] = 6'h08;
    ops[4] = 6'h04; ops[5] = 6'h02; ops[6] = 6'h3F;
`ifdef ILLEGAL_OP_TRAP_EN
    n_ops = 6;
`else
    n_ops = 7;
`endif
    mem_ready = 1'b1;
    opcode = 6'h00;
    do_reset(3);

    run_instr(6'h23, 0, 0);  // lw 0x8C080004
    run_instr(6'h00, 0, 0);  // add 0x01095020
    run_instr(6'h08, 0, 0);  // addi 0x2008000A
    run_instr(6'h04, 0, 0);  // beq 0x11090002
    run_instr(6'h02, 0, 0);  // j 0x08000010
    run_instr(6'h2B, 2, 3);  // sw 0xAC0A0008: 9 cycles
    run_instr(6'h23, 1, 2);

    // reset while a load waits in MEM_READ
    opcode = 6'h23;
    @(posedge clk); #1; mem_ready = 1'b1;
    @(posedge clk); #1; mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_reset_mem_read", {state, MemRead, IorD}, {4'd4, 2'b11});
    #1 reset = 1'b1;
    #1;
    chk("mid_reset_state", state, 0);
    chk("mid_reset_enables", {illegal_op, enables}, 0);
    do_reset(1);

    for (int i = 0; i < 40; i++)
      run_instr(ops[$urandom_range(0, n_ops - 1)], $urandom_range(0, 3), $urandom_range(0, 3));

`ifdef ILLEGAL_OP_TRAP_EN
    opcode = 6'h3F;  // 0xFC000000
    @(posedge clk); #1; mem_ready = 1'b1;
    @(negedge clk); chk("trap_fetch", state, 1);
    @(posedge clk); #1;
    @(negedge clk); chk("trap_decode", state, 2);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1; mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("trap_state", state, 13);
      chk("trap_flag", illegal_op, 1);
      chk("trap_enables", enables, 0);
    end
    do_reset(2);
`else
    run_instr(6'h3F, 1, 0);  // 0xFC000000 executes as a NOP
`endif
    run_instr(6'h23, 0, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
